// File: rtl/nco_clkgen.sv
// Phase-accumulator NCO with wrap-aligned FCW retuning over a valid/ready handshake.
// Optional NCO_RAMP_EN: slew fcw_active toward the target by RAMP_STEP per wrap.
module nco_clkgen #(
    parameter int     ACC_WIDTH   = 16,
    parameter int     PHASE_WIDTH = 8,
    parameter longint FCW_MIN     = 1,
    parameter longint FCW_MAX     = longint'(1) << (ACC_WIDTH - 1),
    parameter longint FCW_RESET   = 256,
    parameter longint RAMP_STEP   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [ACC_WIDTH-1:0]   fcw_in,
    input  logic                   fcw_valid,
    output logic                   fcw_ready,
    output logic                   clk_out,
    output logic                   tick,
    output logic [PHASE_WIDTH-1:0] phase,
    output logic [ACC_WIDTH-1:0]   fcw_active,
    output logic                   clamped
);

    localparam logic [ACC_WIDTH-1:0] MIN_W   = ACC_WIDTH'(FCW_MIN);
    localparam logic [ACC_WIDTH-1:0] MAX_W   = ACC_WIDTH'(FCW_MAX);
    localparam logic [ACC_WIDTH-1:0] RESET_W = ACC_WIDTH'(FCW_RESET);

    if (PHASE_WIDTH < 1 || PHASE_WIDTH > ACC_WIDTH ||
        FCW_MIN < 1 || FCW_MIN > FCW_MAX ||
        FCW_MAX > (longint'(1) << (ACC_WIDTH - 1)) ||
        FCW_RESET < FCW_MIN || FCW_RESET > FCW_MAX ||
        RAMP_STEP < 1 || RAMP_STEP > FCW_MAX) begin : g_bad_cfg
        $error("nco_clkgen: illegal parameter set");
    end

    typedef enum logic {
        RUN,
        PENDING
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] act_q;
    logic [ACC_WIDTH-1:0] pend_q;
    logic                 tick_q;
    logic                 clamped_q;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic                 accept;
    logic                 apply;
    logic                 clamp_hit;
    logic [ACC_WIDTH-1:0] fcw_lim;
    logic [ACC_WIDTH-1:0] fcw_step;

    assign sum   = {1'b0, acc} + {1'b0, act_q};
    assign carry = en & sum[ACC_WIDTH];

    always_comb begin
        fcw_lim   = fcw_in;
        clamp_hit = 1'b0;
        if (fcw_in < MIN_W) begin
            fcw_lim   = MIN_W;
            clamp_hit = 1'b1;
        end else if (fcw_in > MAX_W) begin
            fcw_lim   = MAX_W;
            clamp_hit = 1'b1;
        end
    end

`ifdef NCO_RAMP_EN
    localparam logic [ACC_WIDTH-1:0] STEP_W = ACC_WIDTH'(RAMP_STEP);

    always_comb begin
        fcw_step = pend_q;
        if (pend_q > act_q && (pend_q - act_q) > STEP_W) begin
            fcw_step = act_q + STEP_W;
        end else if (act_q > pend_q && (act_q - pend_q) > STEP_W) begin
            fcw_step = act_q - STEP_W;
        end
    end
`else
    assign fcw_step = pend_q;
`endif

    // A carry seen in PENDING is always later than the acceptance edge,
    // so no extra qualifier is needed to skip a same-cycle wrap.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        apply      = 1'b0;
        unique case (state)
            RUN: begin
                if (fcw_valid) begin
                    accept     = 1'b1;
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (!en || carry) begin
                    apply = 1'b1;
                    if (fcw_step == pend_q) begin
                        state_next = RUN;
                    end
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            act_q     <= RESET_W;
            pend_q    <= RESET_W;
            tick_q    <= 1'b0;
            clamped_q <= 1'b0;
        end else begin
            tick_q    <= carry;
            clamped_q <= accept & clamp_hit;
            if (en) begin
                acc <= sum[ACC_WIDTH-1:0];
            end
            if (accept) begin
                pend_q <= fcw_lim;
            end
            if (apply) begin
                act_q <= fcw_step;
            end
        end
    end

    assign fcw_ready  = (state == RUN);
    assign clk_out    = acc[ACC_WIDTH-1];
    assign phase      = acc[ACC_WIDTH-1 -: PHASE_WIDTH];
    assign tick       = tick_q;
    assign fcw_active = act_q;
    assign clamped    = clamped_q;

endmodule

// File: doc/nco_clkgen.md
Name: nco_clkgen

Overview:
Parametrised all-digital successor to the real-valued VCO model: a numerically controlled oscillator built on a phase accumulator. A frequency control word (FCW) sets the output frequency instead of an analog Vctrl. The FCW is accepted over a valid/ready handshake, clamped to a programmed tuning range, and applied glitch-free only at a phase wrap. Provides a square clock, a wrap tick and truncated phase to drive the sine-wave LUT stage of the project.

Parameters:
ACC_WIDTH, 16, phase accumulator width in bits; FCW width is equal.
PHASE_WIDTH, 8, number of accumulator MSBs exported on phase (must be <= ACC_WIDTH).
FCW_MIN, 1, lowest legal FCW; also the clamp floor.
FCW_MAX, 2**(ACC_WIDTH-1), highest legal FCW (Nyquist); also the clamp ceiling.
FCW_RESET, 256, active FCW after reset; must satisfy FCW_MIN <= FCW_RESET <= FCW_MAX.
RAMP_STEP, 16, maximum FCW change per wrap; used only with NCO_RAMP_EN.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  accumulator run enable
fcw_in  input  ACC_WIDTH  requested frequency control word
fcw_valid  input  1  fcw_in is valid
fcw_ready  output  1  block can accept a new FCW
clk_out  output  1  generated clock (accumulator MSB)
tick  output  1  one-cycle pulse on accumulator wrap
phase  output  PHASE_WIDTH  acc[ACC_WIDTH-1 -: PHASE_WIDTH]
fcw_active  output  ACC_WIDTH  FCW currently in use
clamped  output  1  one-cycle pulse when an accepted FCW was clamped

Behaviour:
- Reset (async assert, sync release):
  - acc = 0, fcw_active = FCW_RESET.
  - No pending word; fcw_ready = 1.
  - tick = 0, clamped = 0.
  - clk_out = 0, phase = 0.
- Accumulator:
  - When en = 1: acc <= acc + fcw_active, modulo 2^ACC_WIDTH.
  - tick <= carry-out of that sum; registered, so it is high in the cycle after acc wraps.
  - clk_out and phase are combinational slices of the acc register, so they carry no extra latency.
- FSM has two states, RUN and PENDING.
  - RUN: fcw_ready = 1. On fcw_valid & fcw_ready, the clamped value of fcw_in is stored in the pending register and the FSM moves to PENDING.
  - Clamp rule: if fcw_in < FCW_MIN the stored value is FCW_MIN; if fcw_in > FCW_MAX it is FCW_MAX. Either case gives clamped = 1 for one cycle, in the cycle after acceptance.
  - PENDING: fcw_ready = 0. fcw_valid is ignored; the source must hold its word until ready.
  - PENDING with en = 1: at the first carry-out occurring strictly after the acceptance cycle, fcw_active <= pending and the FSM returns to RUN. The new FCW affects acc from the following cycle.
  - A wrap in the same cycle as acceptance does not apply the word.
  - PENDING with en = 0: the output is frozen, so the pending word is applied on the next clock edge and the FSM returns to RUN.
- en = 0 in general: acc, clk_out and phase hold their values; tick = 0; the handshake continues to operate.
- fcw_active only ever changes at a wrap or while en = 0, so clk_out never produces a runt pulse caused by retuning.
- Output frequency = f_clk * fcw_active / 2^ACC_WIDTH.
- Reset asserted mid-operation: everything returns to the reset values immediately and any pending word is discarded.

Optional Feature:
NCO_RAMP_EN
- Defined:
  - At each wrap in PENDING, fcw_active moves toward the target by min(RAMP_STEP, |target - fcw_active|). This emulates analog VCO settling.
  - The FSM stays in PENDING (fcw_ready = 0) until fcw_active equals the target.
  - With en = 0, a single step is applied per clock edge.
- Undefined: the target is loaded in one step as described in Behaviour, and RAMP_STEP is unused.

Test Plan:
1. Reset and free-run (ACC_WIDTH=8, FCW_RESET=16, en=1): release rst_n → tick every 16 cycles; clk_out low for 8 cycles then high for 8; fcw_ready=1.
2. Retune: send fcw_in=64 mid-period → fcw_ready=0 on the next cycle; fcw_active changes to 64 only at the next wrap; from then tick has period 4 and fcw_ready=1.
3. Clamp (FCW_MIN=4, FCW_MAX=128): write 200 → fcw_active=128, clamped pulses once; write 0 → fcw_active=4, clamped pulses once; write 50 → no clamped pulse.
4. Enable: drop en with acc=0x37 → acc, phase and clk_out hold and tick stays 0; a word written while en=0 gives fcw_active updated one cycle after acceptance.
5. Backpressure: while PENDING, drive fcw_valid with a different word → that word is ignored; after fcw_ready rises, a held valid is accepted exactly once.
6. Async reset: assert rst_n low mid-period while PENDING → outputs reach reset values without waiting for a clock edge; fcw_active=16 after release (pending discarded). With NCO_RAMP_EN and a 16→64 request at RAMP_STEP=16, fcw_active steps 32, 48, 64 on successive wraps.
